// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, FSM state encoding and address alignment.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int PSEL_W     = 3;

  localparam logic [1:0] APB_ALIGN_MASK = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_READY = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_reg_bank.sv
// CSR array: one synchronous write port, one combinational read port, entry 0 reads as ID.
// Write lands on the clock edge; reads have no latency; no backpressure.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS = 8,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = 32'hA9B0_0001,
  localparam int                   IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] regs_q [NUM_REGS];

  // Entry 0 is never written, so its flop is constant and folds away.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (widx_i != '0)) begin
      regs_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = (ridx_i == '0) ? ID_VALUE : regs_q[ridx_i];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a small CSR bank: 2-cycle transfers plus WAIT_STATES extra access cycles,
// with Pready held low during the wait states; Pslverr flags bad address, misalignment or ID writes.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int                    SEL_IDX     = 0,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    NUM_REGS    = 8,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA9B0_0001,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [PSEL_W-1:0]     Psel,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [APB_ADDR_W-1:0] Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = 4;

  logic sel, setup, access, we;
  logic unused_psel;

  assign sel         = Psel[SEL_IDX];
  assign setup       = sel && !Penable;
  assign access      = sel && Penable;
  assign unused_psel = ^Psel;

  logic [APB_ADDR_W-3:0] word_d;
  logic [IDX_W-1:0]      idx_d;
  logic                  err_d;

  // Word-granular offset; an aligned BASE_ADDR makes this equal to (Paddr-BASE_ADDR)>>2.
  assign word_d = Paddr[APB_ADDR_W-1:2] - BASE_ADDR[APB_ADDR_W-1:2];
  assign idx_d  = word_d[IDX_W-1:0];
  assign err_d  = (Paddr[1:0] != APB_ALIGN_MASK) || (Paddr < BASE_ADDR) ||
                  (word_d >= (APB_ADDR_W-2)'(NUM_REGS)) || (Pwrite && (word_d == '0));

  apb_state_e            state_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic                  write_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [APB_DATA_W-1:0] prdata_q;

  logic [IDX_W-1:0]      ridx;
  logic                  rerr;
  logic [APB_DATA_W-1:0] bank_rdata;
  logic [APB_DATA_W-1:0] rdata_d;

  // Zero-wait reads load Prdata at the setup edge, before idx/err are captured.
  assign ridx    = (state_q == ST_IDLE) ? idx_d : idx_q;
  assign rerr    = (state_q == ST_IDLE) ? err_d : err_q;
  assign rdata_d = rerr ? '0 : bank_rdata;
  assign we      = (state_q == ST_READY) && access && write_q && !err_q;

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk_i   (Hclk),
    .rst_ni  (Hresetn),
    .we_i    (we),
    .widx_i  (idx_q),
    .wdata_i (Pwdata),
    .ridx_i  (ridx),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (setup) begin
            idx_q   <= idx_d;
            err_q   <= err_d;
            write_q <= Pwrite;
            cnt_q   <= CNT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state_q   <= ST_READY;
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              if (!Pwrite) prdata_q <= rdata_d;
            end else begin
              state_q  <= ST_WAIT;
              pready_q <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (!sel) begin
            state_q  <= ST_IDLE;
            pready_q <= 1'b0;
          end else if (access) begin
            if (cnt_q > CNT_W'(1)) begin
              cnt_q <= cnt_q - CNT_W'(1);
            end else begin
              cnt_q     <= '0;
              state_q   <= ST_READY;
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              if (!write_q) prdata_q <= rdata_d;
            end
          end
        end
        ST_READY: begin
          state_q   <= ST_IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  assign Prdata  = prdata_q;
  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Three-slave APB subsystem (wait states 0/3/2) exercised against a register-array reference model.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'hA9B0_0001;
  localparam int          NREG = 8;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic [2:0]  psel    = '0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [31:0] paddr   = '0;
  logic [31:0] pwdata  = '0;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [3][NREG];
  logic [31:0] m_prdata [3];

  always #5 clk = ~clk;

  apb_slave_regfile #(.SEL_IDX(0), .WAIT_STATES(0)) u_s0 (
    .Hclk(clk), .Hresetn(rst_n), .Psel(psel), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));
  apb_slave_regfile #(.SEL_IDX(1), .WAIT_STATES(3)) u_s1 (
    .Hclk(clk), .Hresetn(rst_n), .Psel(psel), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));
  apb_slave_regfile #(.SEL_IDX(2), .WAIT_STATES(2)) u_s2 (
    .Hclk(clk), .Hresetn(rst_n), .Psel(psel), .Penable(penable), .Pwrite(pwrite),
    .Paddr(paddr), .Pwdata(pwdata), .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]));

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : (s == 1) ? 3 : 2;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) begin
      m_prdata[s] = '0;
      for (int i = 0; i < NREG; i++) mem[s][i] = '0;
    end
  endfunction

  function automatic void model_xfer(input int s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] erd, output logic eerr, output int ecyc);
    logic [31:0] off;
    int unsigned idx;
    off  = a - BASE;
    idx  = off / 4;
    eerr = (a % 4 != 0) || (a < BASE) || (idx >= NREG) || (wr && idx == 0);
    if (!wr) begin
      if (eerr)          m_prdata[s] = 32'h0;
      else if (idx == 0) m_prdata[s] = ID;
      else               m_prdata[s] = mem[s][idx];
    end else if (!eerr) begin
      mem[s][idx] = wd;
    end
    erd  = m_prdata[s];
    ecyc = 2 + ws_of(s);
  endfunction

  task automatic apb_xfer(input logic [2:0] sel, input int s, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int cyc, output logic [2:0] other);
    logic [2:0] mask;
    mask = ~(3'b001 << s);
    @(negedge clk);
    psel = sel; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    other = pready & mask;
    @(negedge clk);
    penable = 1'b1;
    cyc = 2;
    other |= pready & mask;
    while (pready[s] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      other |= pready & mask;
    end
    rd  = prdata[s];
    err = pslverr[s];
  endtask

  task automatic apb_idle();
    @(negedge clk);
    psel = '0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (pready[s] !== 1'b0 || pslverr[s] !== 1'b0 || prdata[s] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got rdy=%b err=%b rd=%h, expected 0 0 00000000",
                 s, pready[s], pslverr[s], prdata[s]);
      end
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_id_read();
    logic [31:0] rd; logic err; int cyc; logic [2:0] oth;
    apb_xfer(3'b001, 0, 1'b0, BASE, 32'h0, rd, err, cyc, oth);
    apb_idle();
    m_prdata[0] = ID;
    n_checks++;
    if (cyc !== 2 || rd !== 32'hA9B0_0001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL id_read: got cyc=%0d rd=%h err=%b, expected 2 a9b00001 0", cyc, rd, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int cyc; logic [2:0] oth;
    logic [31:0] erd; logic eerr; int ecyc;
    model_xfer(0, 1'b1, BASE + 8, 32'hDEAD_BEEF, erd, eerr, ecyc);
    apb_xfer(3'b001, 0, 1'b1, BASE + 8, 32'hDEAD_BEEF, rd, err, cyc, oth);
    n_checks++;
    if (cyc !== 2 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_write: got cyc=%0d err=%b, expected 2 0", cyc, err);
    end
    model_xfer(0, 1'b0, BASE + 8, 32'h0, erd, eerr, ecyc);
    apb_xfer(3'b001, 0, 1'b0, BASE + 8, 32'h0, rd, err, cyc, oth);
    apb_idle();
    n_checks++;
    if (cyc !== 2 || rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_read: got cyc=%0d rd=%h err=%b, expected 2 deadbeef 0", cyc, rd, err);
    end
  endtask

  task automatic test_wait_write();
    logic [31:0] rd; logic err; int cyc; logic [2:0] oth;
    logic [31:0] erd; logic eerr; int ecyc;
    model_xfer(1, 1'b1, BASE + 4, 32'h1234_5678, erd, eerr, ecyc);
    apb_xfer(3'b010, 1, 1'b1, BASE + 4, 32'h1234_5678, rd, err, cyc, oth);
    n_checks++;
    if (cyc !== 5 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL wait3_write: got cyc=%0d err=%b, expected 5 0", cyc, err);
    end
    model_xfer(1, 1'b0, BASE + 4, 32'h0, erd, eerr, ecyc);
    apb_xfer(3'b010, 1, 1'b0, BASE + 4, 32'h0, rd, err, cyc, oth);
    apb_idle();
    n_checks++;
    if (cyc !== 5 || rd !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wait3_readback: got cyc=%0d rd=%h, expected 5 12345678", cyc, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc; logic [2:0] oth;
    logic [31:0] erd; logic eerr; int ecyc;
    apb_xfer(3'b001, 0, 1'b0, BASE + 32'h20, 32'h0, rd, err, cyc, oth);
    n_checks++;
    if (cyc !== 2 || err !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_read_idx8: got cyc=%0d err=%b rd=%h, expected 2 1 00000000", cyc, err, rd);
    end
    apb_xfer(3'b001, 0, 1'b1, BASE + 1, 32'h1111_1111, rd, err, cyc, oth);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_write_misaligned: got err=%b rd=%h, expected 1 00000000", err, rd);
    end
    apb_xfer(3'b001, 0, 1'b1, BASE + 9, 32'h2222_2222, rd, err, cyc, oth);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_write_misaligned9: got err=%b, expected 1", err);
    end
    apb_xfer(3'b001, 0, 1'b0, BASE + 8, 32'h0, rd, err, cyc, oth);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_no_side_effect: got rd=%h err=%b, expected deadbeef 0", rd, err);
    end
    apb_xfer(3'b001, 0, 1'b0, BASE - 4, 32'h0, rd, err, cyc, oth);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL err_below_base: got err=%b rd=%h, expected 1 00000000", err, rd);
    end
    apb_xfer(3'b001, 0, 1'b1, BASE, 32'h3333_3333, rd, err, cyc, oth);
    n_checks++;
    if (err !== 1'b1 || cyc !== 2) begin
      n_fail++;
      $display("FAIL err_write_id: got err=%b cyc=%0d, expected 1 2", err, cyc);
    end
    apb_xfer(3'b001, 0, 1'b0, BASE, 32'h0, rd, err, cyc, oth);
    apb_idle();
    m_prdata[0] = ID;
    n_checks++;
    if (rd !== 32'hA9B0_0001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_id_intact: got rd=%h err=%b, expected a9b00001 0", rd, err);
    end
    model_xfer(0, 1'b0, BASE, 32'h0, erd, eerr, ecyc);
  endtask

  task automatic test_spurious_enable();
    @(negedge clk);
    psel = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = BASE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (pready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_enable[%0d]: got rdy=%b, expected 0", k, pready[0]);
      end
    end
    apb_idle();
  endtask

  task automatic test_sel();
    logic [31:0] rd; logic err; int cyc; logic [2:0] oth;
    logic [31:0] erd; logic eerr; int ecyc;
    model_xfer(0, 1'b1, BASE + 16, 32'hCAFE_F00D, erd, eerr, ecyc);
    apb_xfer(3'b001, 0, 1'b1, BASE + 16, 32'hCAFE_F00D, rd, err, cyc, oth);
    apb_idle();
    n_checks++;
    if (oth !== 3'b000) begin
      n_fail++;
      $display("FAIL sel_other_ready: got other=%b, expected 000", oth);
    end
    model_xfer(1, 1'b0, BASE + 16, 32'h0, erd, eerr, ecyc);
    apb_xfer(3'b010, 1, 1'b0, BASE + 16, 32'h0, rd, err, cyc, oth);
    n_checks++;
    if (rd !== erd || cyc !== ecyc) begin
      n_fail++;
      $display("FAIL sel_s1_untouched: got rd=%h cyc=%0d, expected %h %0d", rd, cyc, erd, ecyc);
    end
    model_xfer(1, 1'b1, BASE + 16, 32'h0F0F_0F0F, erd, eerr, ecyc);
    apb_xfer(3'b010, 1, 1'b1, BASE + 16, 32'h0F0F_0F0F, rd, err, cyc, oth);
    model_xfer(1, 1'b0, BASE + 16, 32'h0, erd, eerr, ecyc);
    apb_xfer(3'b010, 1, 1'b0, BASE + 16, 32'h0, rd, err, cyc, oth);
    apb_idle();
    n_checks++;
    if (rd !== 32'h0F0F_0F0F || oth !== 3'b000) begin
      n_fail++;
      $display("FAIL sel_s1_accepted: got rd=%h other=%b, expected 0f0f0f0f 000", rd, oth);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int cyc; logic [2:0] oth;
    logic [31:0] erd; logic eerr; int ecyc;
    model_xfer(2, 1'b1, BASE + 12, 32'h5555_AAAA, erd, eerr, ecyc);
    apb_xfer(3'b100, 2, 1'b1, BASE + 12, 32'h5555_AAAA, rd, err, cyc, oth);
    apb_idle();
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 12; pwdata = 32'hBAD0_BAD0;
    @(negedge clk);
    psel = 3'b000;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_ready[%0d]: got rdy=%b err=%b, expected 0 0", k, pready[2], pslverr[2]);
      end
      @(negedge clk);
    end
    model_xfer(2, 1'b0, BASE + 12, 32'h0, erd, eerr, ecyc);
    apb_xfer(3'b100, 2, 1'b0, BASE + 12, 32'h0, rd, err, cyc, oth);
    apb_idle();
    n_checks++;
    if (rd !== 32'h5555_AAAA || cyc !== 4) begin
      n_fail++;
      $display("FAIL abort_no_write: got rd=%h cyc=%0d, expected 5555aaaa 4", rd, cyc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int cyc; logic [2:0] oth;
    logic [31:0] erd; logic eerr; int ecyc;
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 4; pwdata = 32'h7777_0000;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (pready[s] !== 1'b0 || pslverr[s] !== 1'b0 || prdata[s] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got rdy=%b err=%b rd=%h, expected 0 0 00000000",
                 s, pready[s], pslverr[s], prdata[s]);
      end
    end
    @(negedge clk);
    psel = '0; penable = 1'b0;
    rst_n = 1'b1;
    model_reset();
    model_xfer(2, 1'b0, BASE + 12, 32'h0, erd, eerr, ecyc);
    apb_xfer(3'b100, 2, 1'b0, BASE + 12, 32'h0, rd, err, cyc, oth);
    model_xfer(0, 1'b0, BASE + 8, 32'h0, erd, eerr, ecyc);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_regs_s2: got rd=%h, expected 00000000", rd);
    end
    apb_xfer(3'b001, 0, 1'b0, BASE + 8, 32'h0, rd, err, cyc, oth);
    apb_idle();
    n_checks++;
    if (rd !== erd) begin
      n_fail++;
      $display("FAIL reset_mid_regs_s0: got rd=%h, expected %h", rd, erd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic err; int cyc; logic [2:0] oth;
    logic [31:0] erd; logic eerr; int ecyc;
    logic [31:0] a, wd;
    int s, pick;
    bit wr;
    for (int n = 0; n < 80; n++) begin
      s    = int'($urandom_range(0, 2));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      pick = int'($urandom_range(0, 9));
      if (pick <= 6)      a = BASE + 4 * $urandom_range(0, NREG - 1);
      else if (pick == 7) a = BASE + 4 * $urandom_range(NREG, NREG + 3);
      else if (pick == 8) a = BASE + $urandom_range(1, 31);
      else                a = BASE - 4 * $urandom_range(1, 4);
      model_xfer(s, wr, a, wd, erd, eerr, ecyc);
      apb_xfer(3'b001 << s, s, wr, a, wd, rd, err, cyc, oth);
      n_checks++;
      if (cyc !== ecyc || err !== eerr || rd !== erd || oth !== 3'b000) begin
        n_fail++;
        $display("FAIL random[%0d] s=%0d wr=%0d addr=%h: got cyc=%0d err=%b rd=%h other=%b, expected cyc=%0d err=%b rd=%h other=000",
                 n, s, wr, a, cyc, err, rd, oth, ecyc, eerr, erd);
      end
      if ($urandom_range(0, 1) == 1) apb_idle();
    end
    apb_idle();
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_back_to_back();
    test_wait_write();
    test_errors();
    test_spurious_enable();
    test_sel();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB responder (completer) terminating one Psel line of the AHB-to-APB bridge.
- Holds a small bank of 32-bit control/status registers.
- Supports programmable wait states via Pready and error signalling via Pslverr.
- Serves as the reference peripheral behind the bridge: three instances, one per Psel bit, form the standard APB subsystem.

Parameters:
- SEL_IDX, 0, which bit of the 3-bit Psel bus selects this slave (0..2).
- BASE_ADDR, 32'h8000_0000, byte address of register 0.
- NUM_REGS, 8, number of 32-bit registers (2..16); register 0 is read-only ID.
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0.
- WAIT_STATES, 0, access-phase cycles with Pready low before completion (0..15).

Ports:
- Hclk  in  1  single clock, shared with the bridge.
- Hresetn  in  1  asynchronous, active-low reset.
- Psel  in  3  select bus from the bridge; only Psel[SEL_IDX] is used.
- Penable  in  1  APB access-phase strobe.
- Pwrite  in  1  1 = write, 0 = read.
- Paddr  in  32  byte address.
- Pwdata  in  32  write data.
- Prdata  out  32  read data, valid while Pready=1 in a read access.
- Pready  out  1  transfer completes in the access cycle where this is 1.
- Pslverr  out  1  error response, valid only when Pready=1.

Behaviour:
- Reset (Hresetn=0, async): FSM=ST_IDLE, Prdata=0, Pready=0, Pslverr=0, wait counter=0; registers 1..NUM_REGS-1 reset to 0. Reset mid-transfer aborts it with no register update.
- sel = Psel[SEL_IDX]. Setup = sel && !Penable. Access = sel && Penable.
- Address decode, registered at the setup edge:
  - idx = (Paddr-BASE_ADDR)>>2.
  - err = Paddr[1:0]!=0, or Paddr<BASE_ADDR, or idx>=NUM_REGS, or (Pwrite && idx==0).
- FSM states:
  - ST_IDLE:
    - On setup: capture idx, err, Pwrite; load cnt=WAIT_STATES.
    - If WAIT_STATES==0, go to ST_READY with Pready<=1; otherwise go to ST_WAIT with Pready<=0.
    - Penable=1 seen in ST_IDLE without a prior setup: ignored, stay ST_IDLE.
  - ST_WAIT:
    - Access with cnt>1: cnt--.
    - Access with cnt==1: cnt<=0, Pready<=1, go to ST_READY.
    - sel dropped: abort to ST_IDLE, Pready<=0, no write.
  - ST_READY (Pready=1):
    - Access completes at this edge: for a write with no error, reg[idx]<=Pwdata.
    - Next cycle: Pready<=0, Pslverr<=0, go to ST_IDLE.
    - Setup seen in ST_READY (protocol violation): treated as abort, go to ST_IDLE, no write.
- Read data: loaded when Pready goes high (ST_READY entry) with reg[idx], or ID_VALUE for idx 0, or 0 on err. Prdata holds until the next read completes.
- Pslverr: asserted together with Pready when err=1; errored writes leave all registers unchanged.
- Latency: zero-wait transfer = 2 cycles (setup + access). Each wait state adds 1 cycle.
- Back-to-back: Psel held high with Penable low in the cycle after ST_READY is a new setup, detected in ST_IDLE. No idle cycle is required between transfers.
- Other slave selected (Psel[SEL_IDX]=0): outputs stay at idle values (Pready=0, Pslverr=0, Prdata held).

Decomposition:
- Shared package apb_pkg:
  - State encodings: ST_IDLE=2'b00, ST_WAIT=2'b01, ST_READY=2'b10.
  - APB_ADDR_W=32, APB_DATA_W=32, PSEL_W=3.
  - Address alignment mask 2'b00.
- One sub-module, apb_reg_bank:
  - NUM_REGS x 32 array with one synchronous write port (we, idx, wdata) and one combinational read port.
  - Index 0 hard-wired to ID_VALUE.
  - Async active-low reset of entries 1..NUM_REGS-1 to 0.
- FSM, wait counter and decode stay in the top module.

Test Plan:
- Reset then read 0x8000_0000 (WAIT_STATES=0): Pready=1 on 2nd cycle, Prdata=32'hA9B0_0001, Pslverr=0.
- Write 32'hDEAD_BEEF to 0x8000_0008, then read it back-to-back with Psel held: read returns 32'hDEAD_BEEF; transfers complete on cycles 2 and 4.
- WAIT_STATES=3, write 0x8000_0004: Pready low for 3 access cycles, high on the 4th; register updates only at that edge.
- Error cases, each with Pslverr=1 and Pready=1:
  - Read 0x8000_0020 (idx 8): Prdata=0.
  - Write 0x8000_0001 (misaligned): no register change.
  - Write 0x8000_0000 (ID register): ID still reads 32'hA9B0_0001.
- WAIT_STATES=2: drop Psel in the 1st wait cycle -> FSM returns to ST_IDLE, Pready stays 0, target register unchanged. Separately, assert Hresetn=0 mid-wait -> all outputs 0 immediately.
- SEL_IDX=1 with Psel=3'b001 driving a full write: Pready stays 0 and no register changes. Repeat with Psel=3'b010: transfer accepted.
